six_one_tdm_demux: RTL and testbench

//   Receive end of the 6-channel time-division link. Takes one serial slot stream
//   (one slot per valid beat, slot 0 flagged by in_sync) and rebuilds a 6-slot frame.

---
 rtl/six_one_tdm_demux_if.sv | 26 ++
 rtl/six_one_tdm_demux.sv | 104 ++++++++++
 tb/tb_six_one_tdm_demux.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/six_one_tdm_demux_if.sv
// Bus bundle for the 6-slot TDM receive path: serial slot input side and
// the rebuilt parallel frame side, with status pulses.
interface six_one_tdm_demux_if #(
   parameter int WIDTH = 1
);
   logic [WIDTH-1:0]   in_data;
   logic               in_valid;
   logic               in_sync;
   logic [2:0]         Sel;
   logic [6*WIDTH-1:0] Out;
   logic               out_valid;
   logic               sync_err;
   logic               locked;

   // Receiver side: consumes the slot stream, produces the frame.
   modport slave (
      input  in_data, in_valid, in_sync,
      output Sel, Out, out_valid, sync_err, locked
   );

   // Source side: drives the slot stream, observes the frame.
   modport master (
      output in_data, in_valid, in_sync,
      input  Sel, Out, out_valid, sync_err, locked
   );
endinterface

// File: rtl/six_one_tdm_demux.sv
// Receive end of a 6-channel TDM link. Collects one slot per valid beat,
// aligns on the sync-flagged slot 0, and publishes the whole frame as one
// parallel word once slot 5 arrives. Framing violations raise sync_err.
module six_one_tdm_demux #(
   parameter int WIDTH = 1
) (
   input logic               clk,
   input logic               rst_n,
   six_one_tdm_demux_if.slave bus
);
   typedef enum logic {
      HUNT = 1'b0,
      FILL = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [2:0]         sel_q, sel_d;
   logic [WIDTH-1:0]   shadow_q [5];
   logic [WIDTH-1:0]   shadow_d [5];
   logic [6*WIDTH-1:0] out_q, out_d;
   logic               out_valid_q, out_valid_d;
   logic               sync_err_q, sync_err_d;

   // Next-state and slot capture: hold everything unless a valid beat arrives.
   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      out_d       = out_q;
      out_valid_d = 1'b0;
      sync_err_d  = 1'b0;
      for (int i = 0; i < 5; i++) begin
         shadow_d[i] = shadow_q[i];
      end

      if (bus.in_valid) begin
         case (state_q)
            HUNT: begin
               // Non-sync beats are dropped silently while hunting.
               if (bus.in_sync) begin
                  shadow_d[0] = bus.in_data;
                  sel_d       = 3'd1;
                  state_d     = FILL;
               end
            end
            FILL: begin
               if (bus.in_sync) begin
                  // A sync mid-frame restarts the frame; the partial one is lost.
                  if (sel_q != 3'd0) begin
                     sync_err_d = 1'b1;
                  end
                  shadow_d[0] = bus.in_data;
                  sel_d       = 3'd1;
               end else if (sel_q == 3'd0) begin
                  // Slot 0 without sync: alignment lost, go back to hunting.
                  sync_err_d = 1'b1;
                  state_d    = HUNT;
               end else if (sel_q == 3'd5) begin
                  out_d = {bus.in_data, shadow_q[4], shadow_q[3],
                           shadow_q[2], shadow_q[1], shadow_q[0]};
                  out_valid_d = 1'b1;
                  sel_d       = 3'd0;
               end else begin
                  for (int i = 1; i < 5; i++) begin
                     if (sel_q == 3'(i)) begin
                        shadow_d[i] = bus.in_data;
                     end
                  end
                  sel_d = sel_q + 3'd1;
               end
            end
            default: state_d = HUNT;
         endcase
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= HUNT;
         sel_q       <= 3'd0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         sync_err_q  <= 1'b0;
         for (int i = 0; i < 5; i++) begin
            shadow_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         sync_err_q  <= sync_err_d;
         for (int i = 0; i < 5; i++) begin
            shadow_q[i] <= shadow_d[i];
         end
      end
   end

   assign bus.Sel       = sel_q;
   assign bus.Out       = out_q;
   assign bus.out_valid = out_valid_q;
   assign bus.sync_err  = sync_err_q;
   assign bus.locked    = (state_q == FILL);
endmodule

// File: tb/tb_six_one_tdm_demux.sv
// Bench for six_one_tdm_demux (WIDTH=8): directed framing scenarios followed
// by random traffic, every cycle compared against a queue-based frame model.
module tb_six_one_tdm_demux;
   localparam int WIDTH = 8;

   logic clk = 1'b0;
   logic rst_n;
   int   passed = 0;
   int   total  = 0;

   six_one_tdm_demux_if #(.WIDTH(WIDTH)) bus ();

   six_one_tdm_demux #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference model: the frame in progress is simply the list of slots seen
   // since the last sync; its length is the next slot index.
   logic [7:0]  m_q[$];
   bit          m_locked;
   logic [47:0] m_out;
   bit          m_ov;
   bit          m_err;

   task automatic model_reset();
      m_q.delete();
      m_locked = 0;
      m_out    = '0;
      m_ov     = 0;
      m_err    = 0;
   endtask

   task automatic model_beat(input bit v, input bit s, input logic [7:0] d);
      m_ov  = 0;
      m_err = 0;
      if (!v) return;
      if (s) begin
         if (m_locked && m_q.size() != 0) m_err = 1;
         m_q.delete();
         m_q.push_back(d);
         m_locked = 1;
      end else if (m_locked) begin
         if (m_q.size() == 0) begin
            m_err    = 1;
            m_locked = 0;
         end else begin
            m_q.push_back(d);
            if (m_q.size() == 6) begin
               for (int k = 0; k < 6; k++) m_out[k*8 +: 8] = m_q[k];
               m_ov = 1;
               m_q.delete();
            end
         end
      end
   endtask

   task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s t=%0t observed=%h expected=%h", tag, $time, obs, exp);
      end
   endtask

   task automatic check_all(input string ctx);
      check({ctx, ".Sel"},       48'(bus.Sel),       48'(m_q.size()));
      check({ctx, ".Out"},       bus.Out,            m_out);
      check({ctx, ".out_valid"}, 48'(bus.out_valid), 48'(m_ov));
      check({ctx, ".sync_err"},  48'(bus.sync_err),  48'(m_err));
      check({ctx, ".locked"},    48'(bus.locked),    48'(m_locked));
   endtask

   // One clock with the given beat presented; outputs sampled 1 time unit after the edge.
   task automatic step(input string ctx, input bit v, input bit s, input logic [7:0] d);
      rst_n        = 1'b1;
      bus.in_valid = v;
      bus.in_sync  = s;
      bus.in_data  = d;
      @(posedge clk);
      #1;
      model_beat(v, s, d);
      check_all(ctx);
   endtask

   task automatic reset_cycles(input string ctx, input int n);
      for (int i = 0; i < n; i++) begin
         rst_n        = 1'b0;
         bus.in_valid = 1'b1;
         bus.in_sync  = 1'(i);
         bus.in_data  = 8'($urandom);
         @(posedge clk);
         #1;
         model_reset();
         check_all(ctx);
      end
   endtask

   task automatic frame(input string ctx, input logic [7:0] base);
      step(ctx, 1, 1, base);
      for (int k = 1; k < 6; k++) step(ctx, 1, 0, base + 8'(k));
   endtask

   initial begin
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_sync  = 1'b0;
      bus.in_data  = '0;
      model_reset();

      reset_cycles("reset", 2);

      // Pre-lock beats are dropped without error, then a clean frame.
      for (int i = 0; i < 4; i++) step("prelock", 1, 0, 8'h40 + 8'(i));
      frame("clean", 8'h10);
      check("clean.Out_const", bus.Out, 48'h151413121110);

      // Gapped frame: Sel must hold at 3 across idle cycles.
      step("gap", 1, 1, 8'h10);
      step("gap", 1, 0, 8'h11);
      step("gap", 1, 0, 8'h12);
      for (int i = 0; i < 3; i++) step("gap.idle", 0, 0, 8'hEE);
      for (int k = 3; k < 6; k++) step("gap", 1, 0, 8'h10 + 8'(k));
      check("gap.Out_const", bus.Out, 48'h151413121110);

      // Early sync restarts the frame.
      step("early", 1, 1, 8'hA0);
      step("early", 1, 0, 8'hA1);
      step("early", 1, 0, 8'hA2);
      frame("early.restart", 8'hB0);
      check("early.Out_const", bus.Out, 48'hB5B4B3B2B1B0);

      // Missing sync drops lock; following non-sync beats ignored until relock.
      step("nosync", 1, 0, 8'h77);
      for (int i = 0; i < 3; i++) step("nosync.ign", 1, 0, 8'h78 + 8'(i));
      frame("relock", 8'h20);

      // Back-to-back frames.
      frame("b2b.0", 8'h30);
      frame("b2b.1", 8'h60);

      // Reset partway through a frame discards the partial data.
      step("midrst", 1, 1, 8'hC0);
      step("midrst", 1, 0, 8'hC1);
      step("midrst", 1, 0, 8'hC2);
      reset_cycles("midrst.reset", 2);
      step("midrst.after", 1, 0, 8'hC3);
      step("midrst.after", 1, 0, 8'hC4);
      frame("midrst.frame", 8'hD0);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            reset_cycles("rand.reset", 1);
         end else begin
            step("rand",
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 6) == 0,
                 8'($urandom));
         end
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
